// File: rtl/lipsi_pkg.sv
// Shared constants and state encodings for the Lipsi program loader.
// IMEM_AW/IMEM_DW are also used by the processor's instruction memory.
package lipsi_pkg;

   localparam int IMEM_AW = 8;
   localparam int IMEM_DW = 8;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      LD_SYNC,
      LD_LEN,
      LD_DATA,
      LD_CSUM,
      LD_DONE
   } ld_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/lipsi_uart_rx.sv
// 8N1 UART receiver: rx synchronizer, bit timer and RX FSM.
// Emits one-cycle byte_valid or frame_err pulses per received character.
module lipsi_uart_rx
   import lipsi_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]    sync_reg;
   logic          rx_s;
   rx_state_t     state_reg;
   logic [TW-1:0] timer_reg;
   logic [2:0]    bit_idx_reg;
   logic [7:0]    shift_reg;
   logic          wait_high_reg;

   always_ff @(posedge clk) begin
      if (reset) sync_reg <= 2'b11;
      else       sync_reg <= {sync_reg[0], rx};
   end

   assign rx_s = sync_reg[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= RX_IDLE;
         timer_reg     <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         wait_high_reg <= 1'b0;
         byte_valid    <= 1'b0;
         byte_data     <= '0;
         frame_err     <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state_reg)
            RX_IDLE: begin
               timer_reg <= '0;
               if (!rx_s) state_reg <= RX_START;
            end
            RX_START: begin
               if (timer_reg == HALF_BIT) begin
                  timer_reg   <= '0;
                  bit_idx_reg <= '0;
                  state_reg   <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            RX_DATA: begin
               if (timer_reg == FULL_BIT) begin
                  timer_reg <= '0;
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  if (bit_idx_reg == 3'd7) state_reg <= RX_STOP;
                  else                     bit_idx_reg <= bit_idx_reg + 1'b1;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            RX_STOP: begin
               // After a bad stop bit, hold here until the line idles high again
               if (wait_high_reg) begin
                  if (rx_s) begin
                     wait_high_reg <= 1'b0;
                     state_reg     <= RX_IDLE;
                  end
               end else if (timer_reg == FULL_BIT) begin
                  timer_reg <= '0;
                  if (rx_s) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shift_reg;
                     state_reg  <= RX_IDLE;
                  end else begin
                     frame_err     <= 1'b1;
                     wait_high_reg <= 1'b1;
                  end
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            default: state_reg <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lipsi_uart_loader.sv
// Serial program loader: SYNC, LEN, N payload bytes, checksum; writes imem
// and keeps the processor held until a checksum-verified image is in place.
module lipsi_uart_loader
   import lipsi_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 868,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [IMEM_DW-1:0] imem_wdata,
   output logic               cpu_hold,
   output logic               load_done,
   output logic               load_err
);

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       frame_err;

   ld_state_t  state_reg;
   logic [8:0] len_reg;
   logic [8:0] count_reg;
   logic [7:0] csum_reg;
   logic       hold_reg;

   lipsi_uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .frame_err (frame_err)
   );

   // reset forces the hold in the same cycle rather than one edge later
   assign cpu_hold = hold_reg | reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= LD_SYNC;
         len_reg    <= '0;
         count_reg  <= '0;
         csum_reg   <= '0;
         hold_reg   <= 1'b1;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         imem_we  <= 1'b0;
         load_err <= 1'b0;
         if (frame_err) begin
            if (state_reg == LD_LEN || state_reg == LD_DATA || state_reg == LD_CSUM) begin
               load_err  <= 1'b1;
               state_reg <= LD_SYNC;
            end
         end else if (byte_valid) begin
            case (state_reg)
               LD_SYNC: begin
                  if (byte_data == SYNC_BYTE) state_reg <= LD_LEN;
               end
               LD_LEN: begin
                  len_reg   <= (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
                  count_reg <= '0;
                  csum_reg  <= '0;
                  state_reg <= LD_DATA;
               end
               LD_DATA: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= count_reg[7:0];
                  imem_wdata <= byte_data;
                  csum_reg   <= csum_reg + byte_data;
                  count_reg  <= count_reg + 9'd1;
                  if (count_reg + 9'd1 == len_reg) state_reg <= LD_CSUM;
               end
               LD_CSUM: begin
                  if (byte_data == csum_reg) begin
                     state_reg <= LD_DONE;
                     hold_reg  <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     load_err  <= 1'b1;
                     state_reg <= LD_SYNC;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
